// File: rtl/ultrasonido_scheduler_if.sv
// Bus bundle for the ultrasonic round-robin scheduler.
// Handshake: meas_valid_o is a one-cycle strobe with no ready/back-pressure.
// The consumer must sample meas_channel_o / meas_count_o / meas_timeout_o
// and detected_o in the cycle meas_valid_o is high. The meas_* values also
// hold until the next strobe.
interface ultrasonido_scheduler_if #(
  parameter int N_SENSORS = 2
);
  localparam int CH_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

  logic                 enable_i;
  logic [N_SENSORS-1:0] echo_i;
  logic [N_SENSORS-1:0] trigger_o;
  logic                 busy_o;
  logic                 meas_valid_o;
  logic [CH_W-1:0]      meas_channel_o;
  logic [31:0]          meas_count_o;
  logic                 meas_timeout_o;
  logic [N_SENSORS-1:0] detected_o;
  logic [2:0]           state_o;  // debug view of the scheduler FSM

  modport slave (
    input  enable_i, echo_i,
    output trigger_o, busy_o, meas_valid_o, meas_channel_o, meas_count_o,
           meas_timeout_o, detected_o, state_o
  );

  modport master (
    output enable_i, echo_i,
    input  trigger_o, busy_o, meas_valid_o, meas_channel_o, meas_count_o,
           meas_timeout_o, detected_o, state_o
  );
endinterface

// File: rtl/ultrasonido_scheduler.sv
// Round-robin ultrasonic ranging scheduler. It triggers one sensor at a time,
// times the synchronized echo pulse and reports one measurement per channel.
// A guard gap separates consecutive measurements.
module ultrasonido_scheduler #(
  parameter int N_SENSORS     = 2,
  parameter int TIME_TRIG     = 500,
  parameter int ECHO_TIMEOUT  = 1_900_000,
  parameter int GUARD_CYCLES  = 3_000_000,
  parameter int THRESH_CYCLES = 2915
) (
  input  logic                    clk,
  input  logic                    rst,
  ultrasonido_scheduler_if.slave  bus
);
  localparam int CH_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam logic [31:0] TRIG_LAST  = 32'(TIME_TRIG - 1);
  localparam logic [31:0] TO_LAST    = 32'(ECHO_TIMEOUT - 1);
  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
  localparam logic [31:0] THRESH     = 32'(THRESH_CYCLES);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_SENSORS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRIG       = 3'd1,
    WAIT_ECHO  = 3'd2,
    COUNT_ECHO = 3'd3,
    REPORT     = 3'd4,
    GUARD      = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [N_SENSORS-1:0] sync1_q, sync2_q;
  logic [CH_W-1:0]      ch_q, ch_d;
  // tmr_q is the phase timer: TRIG width, then the echo timeout window
  // (shared by WAIT_ECHO and COUNT_ECHO so it never restarts on echo
  // rise), then the guard gap.
  logic [31:0]          tmr_q, tmr_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [CH_W-1:0]      meas_ch_q, meas_ch_d;
  logic [31:0]          meas_cnt_q, meas_cnt_d;
  logic                 meas_to_q, meas_to_d;
  logic [N_SENSORS-1:0] det_q, det_d;
  logic                 echo_s;
  logic                 load_meas;
  logic [31:0]          rep_cnt;
  logic                 rep_to;

  assign echo_s = sync2_q[ch_q];

  // Two-flop synchronizer on every raw echo line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.echo_i;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and report registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      meas_ch_q  <= '0;
      meas_cnt_q <= '0;
      meas_to_q  <= 1'b0;
      det_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      meas_ch_q  <= meas_ch_d;
      meas_cnt_q <= meas_cnt_d;
      meas_to_q  <= meas_to_d;
      det_q      <= det_d;
    end
  end

  // Next-state logic. Timeout is tested before echo so that it wins a tie.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    load_meas = 1'b0;
    rep_cnt   = '0;
    rep_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          state_d = TRIG;
          tmr_d   = '0;
        end
      end
      TRIG: begin
        if (tmr_q == TRIG_LAST) begin
          state_d = WAIT_ECHO;
          tmr_d   = '0;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      WAIT_ECHO: begin
        if (tmr_q == TO_LAST) begin
          state_d   = REPORT;
          load_meas = 1'b1;
          rep_to    = 1'b1;
        end else begin
          tmr_d = tmr_q + 32'd1;
          if (echo_s) begin
            state_d = COUNT_ECHO;
            cnt_d   = 32'd1;
          end
        end
      end
      COUNT_ECHO: begin
        if (tmr_q == TO_LAST) begin
          state_d   = REPORT;
          load_meas = 1'b1;
          rep_cnt   = cnt_q;
          rep_to    = 1'b1;
        end else if (echo_s) begin
          tmr_d = tmr_q + 32'd1;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
        end else begin
          state_d   = REPORT;
          load_meas = 1'b1;
          rep_cnt   = cnt_q;
        end
      end
      REPORT: begin
        state_d = GUARD;
        tmr_d   = '0;
      end
      GUARD: begin
        if (tmr_q == GUARD_LAST) begin
          tmr_d   = '0;
          ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          state_d = bus.enable_i ? TRIG : IDLE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Report registers load on the transition into REPORT, so they are valid
  // during the strobe cycle and hold afterwards.
  always_comb begin
    meas_ch_d  = meas_ch_q;
    meas_cnt_d = meas_cnt_q;
    meas_to_d  = meas_to_q;
    det_d      = det_q;
    if (load_meas) begin
      meas_ch_d   = ch_q;
      meas_cnt_d  = rep_cnt;
      meas_to_d   = rep_to;
      det_d[ch_q] = !rep_to && (rep_cnt < THRESH);
    end
  end

  assign bus.trigger_o      = (state_q == TRIG) ? (N_SENSORS'(1) << ch_q) : '0;
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.meas_valid_o   = (state_q == REPORT);
  assign bus.meas_channel_o = meas_ch_q;
  assign bus.meas_count_o   = meas_cnt_q;
  assign bus.meas_timeout_o = meas_to_q;
  assign bus.detected_o     = det_q;
  assign bus.state_o        = state_q;
endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// Bench for ultrasonido_scheduler: random echo windows, reference model of
// the echo timing rules, and a scoreboard checked by an independent monitor.
module tb_ultrasonido_scheduler;
  localparam int N  = 2;
  localparam int TT = 4;
  localparam int TO = 50;
  localparam int GC = 10;
  localparam int TH = 20;

  typedef struct packed {
    int          ch;
    logic [31:0] cnt;
    logic        to;
    logic [N-1:0] det;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  int   ch_m;
  logic [N-1:0] det_m;

  ultrasonido_scheduler_if #(.N_SENSORS(N)) bus ();

  ultrasonido_scheduler #(
    .N_SENSORS(N), .TIME_TRIG(TT), .ECHO_TIMEOUT(TO),
    .GUARD_CYCLES(GC), .THRESH_CYCLES(TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Synchronized echo is high in window cycle k (k=0 is the first cycle after
  // the trigger ends) when the raw line was high two cycles earlier.
  function automatic bit sync_hi(input int k, input int d, input int w);
    return (k - 2 >= d) && (k - 2 < d + w);
  endfunction

  // Reference: first echo seen before the last window cycle starts the count;
  // the pulse must end before the last window cycle or it is a timeout.
  function automatic void model(input int d, input int w,
                                output logic [31:0] c, output logic to,
                                output int lat);
    int k0;
    int j;
    k0 = -1;
    for (int k = 0; k < TO - 1; k++)
      if (k0 < 0 && sync_hi(k, d, w)) k0 = k;
    if (k0 < 0) begin
      c = 0; to = 1'b1; lat = TO;
    end else begin
      j = k0 + 1;
      while (j < TO && sync_hi(j, d, w)) j++;
      if (j >= TO - 1) begin
        c = 32'(TO - 1 - k0); to = 1'b1; lat = TO;
      end else begin
        c = 32'(j - k0); to = 1'b0; lat = j + 1;
      end
    end
  endfunction

  // Driver: one measurement with raw echo high for window indices [d, d+w)
  // on the expected channel, random noise on the others.
  task automatic run_meas(input int d, input int w, input int drop_at);
    exp_t        e;
    logic [31:0] c;
    logic        to;
    int          lat;
    int          ch;
    bit          seen;
    bit          done;
    int          i;
    logic [31:0] noise;
    logic [N-1:0] v;
    model(d, w, c, to, lat);
    det_m[ch_m] = !to && (c < TH);
    e.ch = ch_m; e.cnt = c; e.to = to; e.det = det_m; e.lat = lat;
    exp_q.push_back(e);
    ch = ch_m;
    ch_m = (ch_m + 1) % N;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (bus.trigger_o != '0) seen = 1'b1;
    end
    check("trigger_start", seen, 1);
    if (!seen) begin
      void'(exp_q.pop_back());
      return;
    end
    i = -TT;
    done = 1'b0;
    while (!done && i < 300) begin
      noise = $urandom;
      v = noise[N-1:0];
      v[ch] = (i >= d) && (i < d + w);
      bus.echo_i = v;
      if (i == drop_at) bus.enable_i = 1'b0;
      if (bus.meas_valid_o) done = 1'b1;
      else begin
        @(negedge clk);
        i++;
      end
    end
    bus.echo_i = '0;
    check("report_seen", done, 1);
  endtask

  // Monitor: trigger shape, report latency and scoreboard comparison.
  initial begin
    int   trig_len;
    int   trig_ch;
    int   idx;
    bit   active;
    exp_t e;
    trig_len = 0; trig_ch = -1; idx = 0; active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        trig_len = 0; trig_ch = -1; active = 1'b0;
      end else begin
        if (bus.trigger_o != '0) begin
          check("trigger_onehot", $onehot(bus.trigger_o), 1);
          trig_len++;
          for (int b = 0; b < N; b++) if (bus.trigger_o[b]) trig_ch = b;
        end else if (trig_len > 0) begin
          check("trigger_width", trig_len, TT);
          trig_len = 0; active = 1'b1; idx = 0;
        end else if (active) begin
          idx++;
        end
        if (bus.meas_valid_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_report", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("trigger_channel", trig_ch, e.ch);
            check("meas_channel", bus.meas_channel_o, e.ch);
            check("meas_count", bus.meas_count_o, e.cnt);
            check("meas_timeout", bus.meas_timeout_o, e.to);
            check("detected", bus.detected_o, e.det);
            check("report_latency", active ? idx : -1, e.lat);
          end
          active = 1'b0;
        end
      end
    end
  end

  // Main sequence.
  initial begin
    bit trig_seen;
    int d;
    int w;
    checks = 0; errors = 0; ch_m = 0; det_m = '0;
    rst = 1'b0; bus.enable_i = 1'b0; bus.echo_i = '0;
    repeat (3) @(negedge clk);
    check("rst_trigger", bus.trigger_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_valid", bus.meas_valid_o, 0);
    check("rst_channel", bus.meas_channel_o, 0);
    check("rst_count", bus.meas_count_o, 0);
    check("rst_timeout", bus.meas_timeout_o, 0);
    check("rst_detected", bus.detected_o, 0);
    check("rst_state", bus.state_o, 0);
    rst = 1'b1;
    bus.enable_i = 1'b1;

    // Directed cases, including timeout-boundary and threshold-boundary.
    run_meas(0, 12, -100);
    run_meas(0, 30, -100);
    run_meas(0, 0, -100);
    run_meas(-4, 1000, -100);
    run_meas(10, 37, -100);
    run_meas(46, 5, -100);
    run_meas(47, 5, -100);
    run_meas(3, 19, -100);
    run_meas(3, 20, -100);
    run_meas(3, 18, -100);

    for (int n = 0; n < 25; n++) begin
      d = $urandom_range(60, 0) - 4;
      w = ($urandom_range(9, 0) == 0) ? 1000 : $urandom_range(50, 0);
      run_meas(d, w, -100);
    end

    // Enable dropped while counting: measurement completes, then idle.
    run_meas(0, 20, 5);
    repeat (GC + 2) @(negedge clk);
    check("idle_busy", bus.busy_o, 0);
    check("idle_state", bus.state_o, 0);
    trig_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.trigger_o != '0) trig_seen = 1'b1;
    end
    check("no_trigger_when_disabled", trig_seen, 0);

    // Reset pulsed during a trigger on a non-zero channel.
    bus.enable_i = 1'b1;
    if (ch_m == 0) run_meas(5, 5, -100);
    trig_seen = 1'b0;
    for (int t = 0; t < 300 && !trig_seen; t++) begin
      @(negedge clk);
      if (bus.trigger_o != '0) trig_seen = 1'b1;
    end
    check("reset_test_trigger", trig_seen, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_trigger", bus.trigger_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_valid", bus.meas_valid_o, 0);
    check("arst_channel", bus.meas_channel_o, 0);
    check("arst_count", bus.meas_count_o, 0);
    check("arst_timeout", bus.meas_timeout_o, 0);
    check("arst_detected", bus.detected_o, 0);
    @(negedge clk);
    rst = 1'b1;
    ch_m = 0;
    det_m = '0;
    run_meas(3, 8, -100);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
